// File: rtl/offset_sub_pkg.sv
// Shared constants, saturation limits and FSM encoding for the offset
// subtractor (offset_sub and its saturating subtractor).
package offset_sub_pkg;
  localparam int W      = 16;
  localparam int N_ELEM = 24;
  localparam int N      = N_ELEM * W;
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int CNT_W  = 5;

  localparam logic [W-1:0]     SAT_MAX  = 16'h7fff;
  localparam logic [W-1:0]     SAT_MIN  = 16'h8000;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/offset_sub_sat_sub.sv
// Combinational signed a - b, clamped to the W-bit two's complement range.
module offset_sub_sat_sub
  import offset_sub_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         sat_o
);
  logic [W:0] diff;

  always_comb begin
    diff  = {a_i[W-1], a_i} - {b_i[W-1], b_i};
    // Overflow when the two top bits of the widened difference disagree.
    sat_o = diff[W] ^ diff[W-1];
    if (sat_o) y_o = diff[W] ? SAT_MIN : SAT_MAX;
    else       y_o = diff[W-1:0];
  end
endmodule

// File: rtl/offset_sub.sv
// Removes a captured per-element offset from a packed sample vector, one
// element per cycle through a shared saturating subtractor.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in HOLD, where
// out_vec and sat_cnt stay stable until out_ready is seen.
module offset_sub
  import offset_sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  input  logic [N-1:0]     offset_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_vec,
  output logic [CNT_W-1:0] sat_cnt,
  output state_e           state_dbg
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       in_q, in_d;
  logic [N-1:0]       off_q, off_d;
  logic [N-1:0]       out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       elem_y;
  logic               elem_sat;
  logic               accept;

  offset_sub_sat_sub u_sat_sub (
    .a_i   (in_q[idx_q*W +: W]),
    .b_i   (off_q[idx_q*W +: W]),
    .y_o   (elem_y),
    .sat_o (elem_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)          state_d = RUN;
      RUN:     if (idx_q == IDX_LAST) state_d = HOLD;
      HOLD:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
  end

  assign accept = in_ready && in_valid;

  always_comb begin
    idx_d = idx_q;
    in_d  = in_q;
    off_d = off_q;
    out_d = out_q;
    cnt_d = cnt_q;
    if (accept) begin
      in_d  = in_vec;
      off_d = offset_vec;
      cnt_d = '0;
      idx_d = '0;
    end else if (state_q == RUN) begin
      out_d[idx_q*W +: W] = elem_y;
      if (elem_sat) cnt_d = cnt_q + CNT_W'(1);
      // Wrap to 0 on the last element so the counter is clean for HOLD.
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      in_q  <= '0;
      off_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      in_q  <= in_d;
      off_q <= off_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_vec   = out_q;
  assign sat_cnt   = cnt_q;
  assign state_dbg = state_q;
endmodule
